// File: rtl/vproc_pending_wr_tracker_pkg.sv
// Shared constants for the pending-write tracker.
//   VPEND_MAX_DEFAULT : default number of in-flight writers allowed per vector register
package vproc_pending_wr_tracker_pkg;

  localparam int VPEND_MAX_DEFAULT = 3;

endpackage

// File: rtl/vproc_pending_wr_tracker_if.sv
// Dispatch / retire / status bundle of the pending-write tracker.
//   disp_valid, disp_wr_mask, disp_rd_mask : dispatch request and its register masks
//   disp_ready                             : dispatch accepted when disp_valid && disp_ready
//   ret_valid, ret_mask                    : per-port retire strobes and completed-write masks
//   pending_wr, idle, err                  : live pending-write vector, all-clear flag, sticky underflow flag
// master = dispatcher / execution units, slave = tracker.
interface vproc_pending_wr_tracker_if #(
  parameter int RET_PORTS = 2
);

  logic                       disp_valid;
  logic                       disp_ready;
  logic [31:0]                disp_wr_mask;
  logic [31:0]                disp_rd_mask;
  logic [RET_PORTS-1:0]       ret_valid;
  logic [RET_PORTS-1:0][31:0] ret_mask;
  logic [31:0]                pending_wr;
  logic                       idle;
  logic                       err;

  modport master (
    output disp_valid, disp_wr_mask, disp_rd_mask, ret_valid, ret_mask,
    input  disp_ready, pending_wr, idle, err
  );

  modport slave (
    input  disp_valid, disp_wr_mask, disp_rd_mask, ret_valid, ret_mask,
    output disp_ready, pending_wr, idle, err
  );

endinterface

// File: rtl/vproc_pending_wr_cnt.sv
// Occupancy counter for one vector register: counts dispatched-but-not-retired writers.
//   clk_i, sync_rst_ni : clock, synchronous active-low reset
//   inc                : one accepted dispatch writes this register
//   dec                : number of retire ports completing a write to this register
//   cnt                : registered count
//   nz                 : count is non-zero
//   full               : count equals MAX_PEND
//   underflow          : this cycle's update would go negative (clamped to zero)
module vproc_pending_wr_cnt
  import vproc_pending_wr_tracker_pkg::*;
#(
  parameter int MAX_PEND       = VPEND_MAX_DEFAULT,
  parameter int RET_PORTS      = 2,
  parameter bit DONT_CARE_ZERO = 1'b0,
  localparam int CW = $clog2(MAX_PEND + 1),
  localparam int DW = $clog2(RET_PORTS + 1)
) (
  input  logic          clk_i,
  input  logic          sync_rst_ni,
  input  logic          inc,
  input  logic [DW-1:0] dec,
  output logic [CW-1:0] cnt,
  output logic          nz,
  output logic          full,
  output logic          underflow
);

  // Two guard bits above the wider operand keep cnt + 1 - dec exact including the sign.
  localparam int SW = ((CW > DW) ? CW : DW) + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_PEND);

  logic signed [SW-1:0] sum;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  always_comb begin
    sum = $signed({{(SW-CW){1'b0}}, cnt_q})
        + $signed({{(SW-1){1'b0}}, inc})
        - $signed({{(SW-DW){1'b0}}, dec});
    underflow = sum[SW-1];
    if (underflow) begin
      cnt_d = '0;
    end else if (sum > MAX_S) begin
      // Unreachable: dispatch is stalled while any written register is full.
      cnt_d = DONT_CARE_ZERO ? '0 : 'x;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign nz   = |cnt_q;
  assign full = (cnt_q == CW'(MAX_PEND));

endmodule

// File: rtl/vproc_pending_wr_tracker.sv
// Retire-side pending-write tracker. Accumulates the write masks of dispatched vector
// instructions into per-register occupancy counters, clears them on retire, and stalls
// dispatch on read-after-write or counter-full hazards.
//   clk_i, sync_rst_ni : clock, synchronous active-low reset
//   bus (slave)        : dispatch handshake + masks, retire ports, pending_wr / idle / err status
module vproc_pending_wr_tracker
  import vproc_pending_wr_tracker_pkg::*;
#(
  parameter int MAX_PEND       = VPEND_MAX_DEFAULT,
  parameter int RET_PORTS      = 2,
  parameter bit DONT_CARE_ZERO = 1'b0,
  localparam int CW = $clog2(MAX_PEND + 1),
  localparam int DW = $clog2(RET_PORTS + 1)
) (
  input logic                       clk_i,
  input logic                       sync_rst_ni,
  vproc_pending_wr_tracker_if.slave bus
);

  logic [31:0]   inc_vec;
  logic [31:0]   nz_vec;
  logic [31:0]   full_vec;
  logic [31:0]   uf_vec;
  logic [DW-1:0] dec_vec [32];
  logic [CW-1:0] cnt_vec [32];
  logic          raw;
  logic          full_hit;
  logic          disp_ready;
  logic          accept;
  logic          idle_c;
  logic          err_q;

  // Per register: how many retire ports complete a write to it this cycle.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      dec_vec[r] = '0;
      for (int p = 0; p < RET_PORTS; p++) begin
        dec_vec[r] = dec_vec[r] + DW'(bus.ret_valid[p] & bus.ret_mask[p][r]);
      end
    end
  end

  // Hazards look only at registered counts; a retire in the same cycle does not unblock.
  assign raw        = |(bus.disp_rd_mask & nz_vec);
  assign full_hit   = |(bus.disp_wr_mask & full_vec);
  assign disp_ready = !raw && !full_hit;
  assign accept     = bus.disp_valid && disp_ready;
  assign inc_vec    = accept ? bus.disp_wr_mask : 32'h0;

  for (genvar r = 0; r < 32; r++) begin : g_cnt
    vproc_pending_wr_cnt #(
      .MAX_PEND       (MAX_PEND),
      .RET_PORTS      (RET_PORTS),
      .DONT_CARE_ZERO (DONT_CARE_ZERO)
    ) u_cnt (
      .clk_i       (clk_i),
      .sync_rst_ni (sync_rst_ni),
      .inc         (inc_vec[r]),
      .dec         (dec_vec[r]),
      .cnt         (cnt_vec[r]),
      .nz          (nz_vec[r]),
      .full        (full_vec[r]),
      .underflow   (uf_vec[r])
    );
  end

  always_comb begin
    idle_c = 1'b1;
    for (int r = 0; r < 32; r++) begin
      if (cnt_vec[r] != '0) begin
        idle_c = 1'b0;
      end
    end
  end

  // Retires that arrive during reset are dropped, so they cannot set the error flag.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      err_q <= 1'b0;
    end else if (|uf_vec) begin
      err_q <= 1'b1;
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.pending_wr = nz_vec;
  assign bus.idle       = idle_c;
  assign bus.err        = err_q;

endmodule
